// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the single-port data BRAM.
// Port 0 is the processor load/store path, port 1 the loader/debug master.
// Each access takes an ACCESS cycle (BRAM enabled) and a RESP cycle (BRAM
// output valid). The completion pulse and read data come from registers.
module dmem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              done0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              owner_r;
    logic              last_r;
    logic              acc_we_r;
    logic              any_req_s;
    logic              grant_s;
    logic              finish_s;
    logic              win_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_din_s;

    logic              gnt0_r;
    logic              gnt1_r;
    logic              done0_r;
    logic              done1_r;
    logic [DATA_W-1:0] rdata0_r;
    logic [DATA_W-1:0] rdata1_r;
    logic              mem_en_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_din_r;

    assign gnt0     = gnt0_r;
    assign gnt1     = gnt1_r;
    assign done0    = done0_r;
    assign done1    = done1_r;
    assign rdata0   = rdata0_r;
    assign rdata1   = rdata1_r;
    assign mem_en   = mem_en_r;
    assign mem_we   = mem_we_r;
    assign mem_addr = mem_addr_r;
    assign mem_din  = mem_din_r;

    // State register: reset returns the sequencer to IDLE, aborting any access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: requests are only looked at in IDLE and RESP.
    always_comb begin
        any_req_s   = req0 | req1;
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ST_ACCESS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
                if (any_req_s) begin
                    state_nxt_s = ST_ACCESS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode: grant/finish strobes, round-robin winner and its request.
    always_comb begin
        grant_s  = (state_nxt_s == ST_ACCESS);
        finish_s = (state_r == ST_RESP);
        if (req0 && req1) begin
            win_s = ~last_r;
        end else if (req1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        if (win_s) begin
            sel_we_s   = we1;
            sel_addr_s = addr1;
            sel_din_s  = wdata1;
        end else begin
            sel_we_s   = we0;
            sel_addr_s = addr0;
            sel_din_s  = wdata0;
        end
    end

    // Registered outputs: BRAM command on grant, done/rdata on leaving RESP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_r    <= 1'b0;
            last_r     <= 1'b1;
            acc_we_r   <= 1'b0;
            gnt0_r     <= 1'b0;
            gnt1_r     <= 1'b0;
            done0_r    <= 1'b0;
            done1_r    <= 1'b0;
            rdata0_r   <= {DATA_W{1'b0}};
            rdata1_r   <= {DATA_W{1'b0}};
            mem_en_r   <= 1'b0;
            mem_we_r   <= 1'b0;
            mem_addr_r <= {ADDR_W{1'b0}};
            mem_din_r  <= {DATA_W{1'b0}};
        end else begin
            gnt0_r   <= grant_s & ~win_s;
            gnt1_r   <= grant_s & win_s;
            mem_en_r <= grant_s;
            mem_we_r <= grant_s & sel_we_s;
            if (grant_s) begin
                owner_r    <= win_s;
                last_r     <= win_s;
                acc_we_r   <= sel_we_s;
                mem_addr_r <= sel_addr_s;
                mem_din_r  <= sel_din_s;
            end else begin
                owner_r    <= owner_r;
                last_r     <= last_r;
                acc_we_r   <= acc_we_r;
                mem_addr_r <= mem_addr_r;
                mem_din_r  <= mem_din_r;
            end
            // owner_r still names the finishing access here; the new owner
            // written above only takes effect after this edge.
            done0_r <= finish_s & ~owner_r;
            done1_r <= finish_s & owner_r;
            if (finish_s && !acc_we_r && !owner_r) begin
                rdata0_r <= mem_dout;
            end else begin
                rdata0_r <= rdata0_r;
            end
            if (finish_s && !acc_we_r && owner_r) begin
                rdata1_r <= mem_dout;
            end else begin
                rdata1_r <= rdata1_r;
            end
        end
    end

endmodule
